// File: rtl/decode_issue_queue.sv
// Fetch-to-rename instruction queue: a small FIFO that classifies each raw instruction
// by opcode at enqueue and presents the head entry to the decode field extractor.
module decode_issue_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [PC_W-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [24:0]              out_instruction_data,
    output logic [6:0]               out_opcode,
    output logic [1:0]               out_group,
    output logic                     out_specifier,
    output logic                     out_illegal,
    output logic [PC_W-1:0]          out_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         stall_cycles
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] STALL_ONE = CNT_W'(1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Per-entry storage; contents are don't-care until written, so no reset.
    logic [24:0]     data_mem  [DEPTH];
    logic [6:0]      op_mem    [DEPTH];
    logic [1:0]      group_mem [DEPTH];
    logic            spec_mem  [DEPTH];
    logic            ill_mem   [DEPTH];
    logic [PC_W-1:0] pc_mem    [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic [6:0] in_opcode;
    logic [1:0] cls_group;
    logic       cls_spec;
    logic       cls_illegal;
    logic       push;
    logic       pop;

    assign in_opcode = in_instr[6:0];

    always_comb begin
        cls_group   = 2'b00;
        cls_spec    = 1'b0;
        cls_illegal = 1'b0;
        case (in_opcode)
            OP_R: begin
                cls_group = 2'b01;
            end
            OP_I_ALU, OP_LOAD, OP_JALR: begin
                cls_group = 2'b01;
                cls_spec  = 1'b1;
            end
            OP_STORE: begin
                cls_group = 2'b10;
            end
            OP_BRANCH: begin
                cls_group = 2'b10;
                cls_spec  = 1'b1;
            end
            OP_LUI, OP_AUIPC, OP_JAL: begin
                cls_group = 2'b00;
            end
            default: begin
                cls_illegal = 1'b1;
            end
        endcase
    end

    // Handshake: a transfer happens on an edge where valid and ready are both high;
    // ready depends only on registered occupancy, never combinationally on the consumer.
    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            data_mem[wr_ptr]  <= in_instr[31:7];
            op_mem[wr_ptr]    <= in_opcode;
            group_mem[wr_ptr] <= cls_group;
            spec_mem[wr_ptr]  <= cls_spec;
            ill_mem[wr_ptr]   <= cls_illegal;
            pc_mem[wr_ptr]    <= in_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (out_valid && !out_ready && !flush && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + STALL_ONE;
        end
    end

    // Head fields are forced to zero when empty so stale storage never leaks out.
    always_comb begin
        out_instruction_data = '0;
        out_opcode           = '0;
        out_group            = '0;
        out_specifier        = 1'b0;
        out_illegal          = 1'b0;
        out_pc               = '0;
        if (out_valid) begin
            out_instruction_data = data_mem[rd_ptr];
            out_opcode           = op_mem[rd_ptr];
            out_group            = group_mem[rd_ptr];
            out_specifier        = spec_mem[rd_ptr];
            out_illegal          = ill_mem[rd_ptr];
            out_pc               = pc_mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed bench for decode_issue_queue: a negedge monitor keeps a scoreboard queue of
// expected entries (with hand-assigned classifications) and checks head, occupancy and stalls.
module tb_decode_issue_queue;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam int CNT_W = 16;
    localparam int EW    = 25 + 7 + 2 + 1 + 1 + PC_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [31:0]       in_instr = '0;
    logic [PC_W-1:0]   in_pc = '0;
    logic              in_ready;
    logic              out_valid;
    logic [24:0]       out_instruction_data;
    logic [6:0]        out_opcode;
    logic [1:0]        out_group;
    logic              out_specifier;
    logic              out_illegal;
    logic [PC_W-1:0]   out_pc;
    logic [$clog2(DEPTH):0] count;
    logic [CNT_W-1:0]  stall_cycles;

    logic [1:0]        cur_grp = '0;
    logic              cur_spec = 1'b0;
    logic              cur_ill = 1'b0;

    logic [EW-1:0]     exp_q[$];
    logic [CNT_W-1:0]  exp_stall = '0;
    int                n_checks = 0;
    int                n_fail = 0;

    logic [31:0]       vec_instr [8];
    logic [1:0]        vec_grp   [8];
    logic              vec_spec  [8];
    logic              vec_ill   [8];

    decode_issue_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction_data(out_instruction_data), .out_opcode(out_opcode),
        .out_group(out_group), .out_specifier(out_specifier), .out_illegal(out_illegal),
        .out_pc(out_pc), .count(count), .stall_cycles(stall_cycles)
    );

    // clock/reset block
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [1:0] g, input logic s, input logic il);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        cur_grp  = g;
        cur_spec = s;
        cur_ill  = il;
    endtask

    task automatic push1(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [1:0] g, input logic s, input logic il);
        drive(instr, pc, g, s, il);
        step();
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // scoreboard monitor: compare current state, then advance the model for the next edge
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_stall = '0;
        end else begin
            int sz;
            logic [EW-1:0] head;
            sz = exp_q.size();
            check("count", EW'(count), EW'(sz));
            check("in_ready", EW'(in_ready), EW'(sz != DEPTH));
            check("out_valid", EW'(out_valid), EW'(sz != 0));
            check("stall_cycles", EW'(stall_cycles), EW'(exp_stall));
            if (sz != 0) begin
                head = exp_q[0];
                check("head_data", EW'(out_instruction_data), EW'(head[EW-1 -: 25]));
                check("head_opcode", EW'(out_opcode), EW'(head[PC_W+10 -: 7]));
                check("head_group", EW'(out_group), EW'(head[PC_W+3 -: 2]));
                check("head_spec", EW'(out_specifier), EW'(head[PC_W+1]));
                check("head_illegal", EW'(out_illegal), EW'(head[PC_W]));
                check("head_pc", EW'(out_pc), EW'(head[PC_W-1:0]));
            end else begin
                check("empty_zero", {out_instruction_data, out_opcode, out_group,
                                     out_specifier, out_illegal, out_pc}, '0);
            end
            if (sz != 0 && !out_ready && !flush && exp_stall != '1) begin
                exp_stall = exp_stall + 1'b1;
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                if (sz != 0 && out_ready) begin
                    void'(exp_q.pop_front());
                end
                if (in_valid && sz != DEPTH) begin
                    exp_q.push_back({in_instr[31:7], in_instr[6:0], cur_grp, cur_spec, cur_ill, in_pc});
                end
            end
        end
    end

    initial begin
        // hand-classified vectors: lw, jalr, lui, auipc, jal, addi, add, sw
        vec_instr[0] = 32'h00052283; vec_grp[0] = 2'b01; vec_spec[0] = 1'b1; vec_ill[0] = 1'b0;
        vec_instr[1] = 32'h000080E7; vec_grp[1] = 2'b01; vec_spec[1] = 1'b1; vec_ill[1] = 1'b0;
        vec_instr[2] = 32'h000122B7; vec_grp[2] = 2'b00; vec_spec[2] = 1'b0; vec_ill[2] = 1'b0;
        vec_instr[3] = 32'h00000317; vec_grp[3] = 2'b00; vec_spec[3] = 1'b0; vec_ill[3] = 1'b0;
        vec_instr[4] = 32'h0000006F; vec_grp[4] = 2'b00; vec_spec[4] = 1'b0; vec_ill[4] = 1'b0;
        vec_instr[5] = 32'h00150513; vec_grp[5] = 2'b01; vec_spec[5] = 1'b1; vec_ill[5] = 1'b0;
        vec_instr[6] = 32'h00B50533; vec_grp[6] = 2'b01; vec_spec[6] = 1'b0; vec_ill[6] = 1'b0;
        vec_instr[7] = 32'h00B52023; vec_grp[7] = 2'b10; vec_spec[7] = 1'b0; vec_ill[7] = 1'b0;

        // reset state
        #2;
        check("rst_out_valid", EW'(out_valid), '0);
        check("rst_in_ready", EW'(in_ready), EW'(1));
        check("rst_count", EW'(count), '0);
        check("rst_stall", EW'(stall_cycles), '0);
        #10;
        rst = 1'b0;

        // 1: add is visible one cycle after enqueue
        step();
        push1(32'h00B50533, 32'h1000, 2'b01, 1'b0, 1'b0);
        idle();
        check("t1_valid", EW'(out_valid), EW'(1));
        check("t1_group", EW'(out_group), EW'(2'b01));
        check("t1_spec", EW'(out_specifier), '0);
        check("t1_data", EW'(out_instruction_data), EW'(25'h0016A0A));
        check("t1_illegal", EW'(out_illegal), '0);
        step();
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // 2: sw then beq held under backpressure, then released in order
        push1(32'h00B52023, 32'h1004, 2'b10, 1'b0, 1'b0);
        push1(32'h00B50463, 32'h1008, 2'b10, 1'b1, 1'b0);
        idle();
        repeat (3) step();
        check("t2_head_group", EW'(out_group), EW'(2'b10));
        check("t2_head_spec", EW'(out_specifier), '0);
        out_ready = 1'b1;
        step();
        check("t2_next_group", EW'(out_group), EW'(2'b10));
        check("t2_next_spec", EW'(out_specifier), EW'(1));
        step();
        out_ready = 1'b0;
        check("t2_empty", EW'(out_valid), '0);

        // 3: fill, then pop with a push attempt while full
        for (int i = 0; i < DEPTH; i++) begin
            push1(vec_instr[i], 32'h2000 + 32'(4 * i), vec_grp[i], vec_spec[i], vec_ill[i]);
        end
        idle();
        check("t3_full_ready", EW'(in_ready), '0);
        check("t3_full_count", EW'(count), EW'(DEPTH));
        drive(vec_instr[4], 32'h2010, vec_grp[4], vec_spec[4], vec_ill[4]);
        out_ready = 1'b1;
        step();
        idle();
        out_ready = 1'b0;
        check("t3_blocked_count", EW'(count), EW'(DEPTH - 1));
        out_ready = 1'b1;
        repeat (DEPTH - 1) step();
        out_ready = 1'b0;
        check("t3_drained", EW'(count), '0);

        // 4: steady push+pop at occupancy 2 across pointer wrap
        push1(vec_instr[5], 32'h3000, vec_grp[5], vec_spec[5], vec_ill[5]);
        push1(vec_instr[6], 32'h3004, vec_grp[6], vec_spec[6], vec_ill[6]);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(vec_instr[i % 8], 32'h3100 + 32'(4 * i), vec_grp[i % 8], vec_spec[i % 8], vec_ill[i % 8]);
            step();
            check("t4_count", EW'(count), EW'(2));
        end
        idle();
        repeat (2) step();
        out_ready = 1'b0;

        // 5: illegal opcode, then flush with a concurrent push
        push1(32'h0000007F, 32'h4000, 2'b00, 1'b0, 1'b1);
        idle();
        check("t5_illegal", EW'(out_illegal), EW'(1));
        check("t5_group", EW'(out_group), '0);
        push1(vec_instr[7], 32'h4004, vec_grp[7], vec_spec[7], vec_ill[7]);
        push1(vec_instr[0], 32'h4008, vec_grp[0], vec_spec[0], vec_ill[0]);
        idle();
        check("t5_count3", EW'(count), EW'(3));
        drive(vec_instr[2], 32'h400C, vec_grp[2], vec_spec[2], vec_ill[2]);
        flush = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        idle();
        out_ready = 1'b0;
        check("t5_flush_count", EW'(count), '0);
        check("t5_flush_valid", EW'(out_valid), '0);
        check("t5_flush_ready", EW'(in_ready), EW'(1));
        step();

        // 6: asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) begin
            push1(vec_instr[i + 3], 32'h5000 + 32'(4 * i), vec_grp[i + 3], vec_spec[i + 3], vec_ill[i + 3]);
        end
        idle();
        check("t6_count3", EW'(count), EW'(3));
        rst = 1'b1;
        #1;
        check("t6_rst_valid", EW'(out_valid), '0);
        check("t6_rst_count", EW'(count), '0);
        check("t6_rst_stall", EW'(stall_cycles), '0);
        check("t6_rst_ready", EW'(in_ready), EW'(1));
        @(negedge clk);
        #2;
        rst = 1'b0;
        step();
        step();
        check("t6_post_count", EW'(count), '0);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
